// File: rtl/serial_fifo_ctrl_if.sv
// CPU-side register window between devctrl and serial_fifo_ctrl.
// Single-cycle strobe per access; read data is combinational within the strobe cycle.
interface serial_fifo_ctrl_if;
    logic        enable_i;
    logic        readEnable_i;
    logic [1:0]  addr_i;
    logic [31:0] dataSave_i;
    logic [31:0] dataLoad_o;

    modport master (
        output enable_i,
        output readEnable_i,
        output addr_i,
        output dataSave_i,
        input  dataLoad_o
    );

    modport slave (
        input  enable_i,
        input  readEnable_i,
        input  addr_i,
        input  dataSave_i,
        output dataLoad_o
    );
endinterface

// File: rtl/serial_fifo_ctrl.sv
// Buffered UART controller: RX/TX FIFOs, status/ctrl registers, level and TX-empty interrupts.
// Reads are same-cycle; full FIFOs drop bytes and set sticky overrun/overflow flags.
module serial_fifo_ctrl #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_fifo_ctrl_if.slave     bus,
    output logic                  int_o,
    input  logic                  rxdReady_i,
    input  logic [7:0]            rxdData_i,
    input  logic                  txdBusy_i,
    output logic                  txdStart_o,
    output logic [7:0]            txdData_o
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_HOLD, S_WAIT} tx_state_t;

    tx_state_t state, state_nxt;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;

    logic       rxie, txie, rxovr, txovf;
    logic [7:0] thresh;
    logic       tx_load;

    logic acc_rd, acc_wr, data_rd, data_wr, ctrl_wr, thr_wr, flush, ovf_clr;
    logic rx_empty, rx_full, rx_pop, rx_push, rx_drop;
    logic tx_empty, tx_full, tx_pop, tx_push, tx_drop, tx_idle;
    logic [7:0]  thr_eff;
    logic        int_d;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^bus.dataSave_i[31:8];

    assign acc_rd  = bus.enable_i & bus.readEnable_i;
    assign acc_wr  = bus.enable_i & ~bus.readEnable_i;
    assign data_rd = acc_rd & (bus.addr_i == 2'd0);
    assign data_wr = acc_wr & (bus.addr_i == 2'd0);
    assign ctrl_wr = acc_wr & (bus.addr_i == 2'd2);
    assign thr_wr  = acc_wr & (bus.addr_i == 2'd3);
    assign flush   = ctrl_wr & bus.dataSave_i[3];
    assign ovf_clr = ctrl_wr & bus.dataSave_i[2];

    // A pop in the same cycle frees the slot, so a full RX still accepts the byte.
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_FULL);
    assign rx_pop   = data_rd & ~rx_empty;
    assign rx_push  = rxdReady_i & (~rx_full | rx_pop);
    assign rx_drop  = rxdReady_i & rx_full & ~rx_pop;

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL);
    assign tx_push  = data_wr & ~tx_full;
    assign tx_drop  = data_wr & tx_full;
    assign tx_pop   = (state == S_START) & ~tx_empty & ~flush;
    assign tx_idle  = tx_empty & (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rx_push && !flush) rx_mem[rx_wr_ptr] <= rxdData_i;
        if (tx_push && !flush) tx_mem[tx_wr_ptr] <= bus.dataSave_i[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + RX_CW'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - RX_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + TX_CW'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - TX_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // HOLD ignores busy for one cycle because the transmitter raises busy a cycle late.
    always_comb begin
        state_nxt  = state;
        txdStart_o = 1'b0;
        tx_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!tx_empty && !txdBusy_i) begin
                    state_nxt = S_START;
                    tx_load   = 1'b1;
                end
            end
            S_START: begin
                txdStart_o = 1'b1;
                state_nxt  = S_HOLD;
            end
            S_HOLD:  state_nxt = S_WAIT;
            S_WAIT:  if (!txdBusy_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       txdData_o <= 8'h00;
        else if (tx_load) txdData_o <= tx_mem[tx_rd_ptr];
    end

    // A new overrun in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxovr  <= 1'b0;
            txovf  <= 1'b0;
            rxie   <= 1'b0;
            txie   <= 1'b0;
            thresh <= 8'd1;
            int_o  <= 1'b0;
        end else begin
            if (rx_drop)      rxovr <= 1'b1;
            else if (ovf_clr) rxovr <= 1'b0;
            if (tx_drop)      txovf <= 1'b1;
            else if (ovf_clr) txovf <= 1'b0;
            if (ctrl_wr) begin
                rxie <= bus.dataSave_i[0];
                txie <= bus.dataSave_i[1];
            end
            if (thr_wr) thresh <= bus.dataSave_i[7:0];
            int_o <= int_d;
        end
    end

    assign thr_eff = (thresh == 8'd0) ? 8'd1 : thresh;
    assign int_d   = (rxie & ((9'(rx_count) >= {1'b0, thr_eff}) | rxovr)) | (txie & tx_idle);

    assign status = {8'h00, 8'(tx_count), 8'(rx_count), 3'b000,
                     tx_idle, txovf, rxovr, ~rx_empty, ~tx_full};

    always_comb begin
        bus.dataLoad_o = 32'h0;
        if (acc_rd) begin
            case (bus.addr_i)
                2'd0:    if (!rx_empty) bus.dataLoad_o = {24'h0, rx_mem[rx_rd_ptr]};
                2'd1:    bus.dataLoad_o = status;
                2'd2:    bus.dataLoad_o = {30'h0, txie, rxie};
                default: bus.dataLoad_o = {24'h0, thresh};
            endcase
        end
    end
endmodule
